// File: rtl/seg_disp_sched.sv
// Round-robin scheduler sharing the 8-digit display between four word sources.
// Grants one requester at a time for a dwell period; key pulse skips early.
module seg_disp_sched #(
  parameter int          DWELL      = 50_000_000,
  parameter int          CNT_W      = 26,
  parameter logic [31:0] BLANK_WORD = 32'h0000_0000
) (
  input  logic        CLOCK_50,
  input  logic        rst,
  input  logic [3:0]  req,
  input  logic [31:0] data0,
  input  logic [31:0] data1,
  input  logic [31:0] data2,
  input  logic [31:0] data3,
  input  logic        next_pulse,
  input  logic        pause,
  output logic [31:0] disp_data,
  output logic        disp_valid,
  output logic [3:0]  grant,
  output logic [1:0]  src_idx
);

  typedef enum logic {IDLE, SHOW} state_t;

  localparam logic [CNT_W-1:0] LAST = CNT_W'(DWELL - 1);

  state_t           state, state_nxt;
  logic [1:0]       ptr, ptr_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [31:0]      data_nxt;
  logic             valid_nxt;
  logic [3:0]       grant_nxt;
  logic [1:0]       src_nxt;
  logic [1:0]       win;
  logic [1:0]       cand;
  logic             win_ok;
  logic             adv;

  function automatic logic [31:0] pick(input logic [1:0] idx);
    logic [31:0] w;
    unique case (idx)
      2'd0:    w = data0;
      2'd1:    w = data1;
      2'd2:    w = data2;
      default: w = data3;
    endcase
    return w;
  endfunction

  // Walk downward so the nearest requester after ptr wins; ptr itself is last.
  always_comb begin
    win    = ptr;
    win_ok = 1'b0;
    cand   = 2'd0;
    for (int k = 4; k >= 1; k--) begin
      cand = ptr + 2'(k);
      if (req[cand]) begin
        win    = cand;
        win_ok = 1'b1;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    ptr_nxt   = ptr;
    cnt_nxt   = cnt;
    data_nxt  = disp_data;
    valid_nxt = disp_valid;
    grant_nxt = grant;
    src_nxt   = src_idx;
    adv       = 1'b0;
    unique case (state)
      IDLE: begin
        data_nxt = BLANK_WORD;
        if (win_ok) begin
          state_nxt = SHOW;
          ptr_nxt   = win;
          cnt_nxt   = '0;
          data_nxt  = pick(win);
          valid_nxt = 1'b1;
          grant_nxt = 4'(1) << win;
          src_nxt   = win;
        end
      end
      default: begin
        adv = (cnt == LAST && !pause) || next_pulse || !req[src_idx];
        if (!adv) begin
          data_nxt = pick(src_idx);
          if (!pause) cnt_nxt = cnt + 1'b1;
        end else if (win_ok) begin
          ptr_nxt   = win;
          cnt_nxt   = '0;
          data_nxt  = pick(win);
          grant_nxt = 4'(1) << win;
          src_nxt   = win;
        end else begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
          data_nxt  = BLANK_WORD;
          valid_nxt = 1'b0;
          grant_nxt = 4'b0000;
        end
      end
    endcase
  end

  always_ff @(posedge CLOCK_50) begin
    if (rst) begin
      state      <= IDLE;
      ptr        <= 2'd3;
      cnt        <= '0;
      disp_data  <= BLANK_WORD;
      disp_valid <= 1'b0;
      grant      <= 4'b0000;
      src_idx    <= 2'd0;
    end else begin
      state      <= state_nxt;
      ptr        <= ptr_nxt;
      cnt        <= cnt_nxt;
      disp_data  <= data_nxt;
      disp_valid <= valid_nxt;
      grant      <= grant_nxt;
      src_idx    <= src_nxt;
    end
  end

endmodule

// File: tb/tb_seg_disp_sched.sv
// Scoreboard bench for seg_disp_sched: directed plan then random traffic
// against a cycle-level reference of the scheduling rules.
module tb_seg_disp_sched;

  localparam int          DWELL = 8;
  localparam logic [31:0] BLANK = 32'h0000_0000;

  logic        CLOCK_50 = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  req = 4'b0000;
  logic [31:0] data0 = '0;
  logic [31:0] data1 = '0;
  logic [31:0] data2 = '0;
  logic [31:0] data3 = '0;
  logic        next_pulse = 1'b0;
  logic        pause = 1'b0;
  logic [31:0] disp_data;
  logic        disp_valid;
  logic [3:0]  grant;
  logic [1:0]  src_idx;

  seg_disp_sched #(.DWELL(DWELL), .CNT_W(4), .BLANK_WORD(BLANK)) dut (
    .CLOCK_50  (CLOCK_50),
    .rst       (rst),
    .req       (req),
    .data0     (data0),
    .data1     (data1),
    .data2     (data2),
    .data3     (data3),
    .next_pulse(next_pulse),
    .pause     (pause),
    .disp_data (disp_data),
    .disp_valid(disp_valid),
    .grant     (grant),
    .src_idx   (src_idx)
  );

  always #10 CLOCK_50 = ~CLOCK_50;

  typedef struct packed {
    logic [3:0]  g;
    logic        v;
    logic [1:0]  s;
    logic [31:0] d;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   failures = 0;

  // Reference: who is on screen, for how long, and who was served last.
  bit m_show = 0;
  int m_idx  = 0;
  int m_ptr  = 3;
  int m_el   = 0;

  function automatic int arb(input int p, input logic [3:0] rq);
    for (int k = 1; k <= 4; k++)
      if (rq[(p + k) % 4]) return (p + k) % 4;
    return -1;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, exp);
    end
  endtask

  always @(posedge CLOCK_50) begin
    #1;
    if (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      chk("grant", 32'(grant), 32'(e.g));
      chk("disp_valid", 32'(disp_valid), 32'(e.v));
      chk("src_idx", 32'(src_idx), 32'(e.s));
      chk("disp_data", disp_data, e.d);
    end
  end

  task automatic step(input logic r, input logic [3:0] rq, input logic np,
                      input logic ps, input bit rnd);
    logic [31:0] d [4];
    logic [31:0] ed;
    int w;
    bit adv;
    @(negedge CLOCK_50);
    rst = r; req = rq; next_pulse = np; pause = ps;
    if (rnd) begin
      data0 = $urandom; data1 = $urandom;
      data2 = $urandom; data3 = $urandom;
    end else begin
      data0 = 32'h1111_1111; data1 = 32'h2222_2222;
      data2 = 32'h3333_3333; data3 = 32'h4444_4444;
    end
    d[0] = data0; d[1] = data1; d[2] = data2; d[3] = data3;
    ed = BLANK;
    if (r) begin
      m_show = 0; m_idx = 0; m_ptr = 3; m_el = 0;
    end else if (!m_show) begin
      w = arb(m_ptr, rq);
      if (w >= 0) begin
        m_show = 1; m_idx = w; m_ptr = w; m_el = 0; ed = d[w];
      end
    end else begin
      adv = (m_el == DWELL - 1 && !ps) || np || !rq[m_idx];
      if (!adv) begin
        ed = d[m_idx];
        if (!ps) m_el++;
      end else begin
        w = arb(m_ptr, rq);
        m_el = 0;
        if (w >= 0) begin
          m_idx = w; m_ptr = w; ed = d[w];
        end else begin
          m_show = 0;
        end
      end
    end
    sb.push_back('{g: m_show ? 4'(1 << m_idx) : 4'b0, v: m_show,
                   s: 2'(m_idx), d: ed});
  endtask

  task automatic run(input int n, input logic [3:0] rq, input logic ps);
    for (int i = 0; i < n; i++) step(0, rq, 0, ps, 0);
  endtask

  initial begin
    logic [3:0] rr;
    logic       pp;
    // reset and idle
    step(1, 4'b0000, 0, 0, 0);
    step(1, 4'b0000, 0, 0, 0);
    run(20, 4'b0000, 0);
    // rotation over all four sources
    run(40, 4'b1111, 0);
    // skip mid-dwell, then skip coinciding with expiry
    step(1, 4'b0000, 0, 0, 0);
    run(4, 4'b0101, 0);
    step(0, 4'b0101, 1, 0, 0);
    for (int i = 0; i < 20 && m_el != DWELL - 1; i++) run(1, 4'b0101, 0);
    step(0, 4'b0101, 1, 0, 0);
    run(10, 4'b0101, 0);
    // pause, skip while paused, then finish remaining dwell
    run(3, 4'b1111, 0);
    run(20, 4'b1111, 1);
    step(0, 4'b1111, 1, 1, 0);
    run(3, 4'b1111, 1);
    run(14, 4'b1111, 0);
    // sole requester and drops
    run(20, 4'b0010, 0);
    run(3, 4'b0000, 0);
    run(3, 4'b0010, 0);
    run(2, 4'b1010, 0);
    run(3, 4'b1000, 0);
    // reset while source 2 holds the display
    step(1, 4'b0000, 0, 0, 0);
    run(3, 4'b0100, 0);
    step(1, 4'b1111, 0, 0, 0);
    run(12, 4'b1111, 0);
    // random traffic
    rr = 4'b1111;
    pp = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(15) == 0) rr = 4'($urandom);
      if ($urandom_range(20) == 0) pp = ~pp;
      step($urandom_range(499) == 0, rr, $urandom_range(24) == 0, pp, 1);
    end
    @(negedge CLOCK_50);
    @(negedge CLOCK_50);
    chk("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/seg_disp_sched.md
Name: seg_disp_sched

Overview:
Round-robin scheduler that shares the 8-digit seven-segment display path between four independent 32-bit digit sources. Each source packs 8 nibbles, digit 7 in [31:28]. The block grants one requesting source at a time and holds it on the display for a programmable dwell period. A debounced key pulse skips to the next source early. Its output word drives the scrolling stage and the 8-digit LUT in place of a hard-wired concatenation.

Parameters:
DWELL, 50_000_000, dwell time per grant in CLOCK_50 cycles (at least 2)
CNT_W, 26, dwell counter width (2^CNT_W must exceed DWELL-1)
BLANK_WORD, 32'h0000_0000, word driven when no source is granted

Ports:
CLOCK_50  input  1  system clock, all logic on rising edge
rst  input  1  synchronous reset, active-high
req  input  4  per-source display request, level-sensitive, bit i = source i
data0  input  32  source 0 digit word
data1  input  32  source 1 digit word
data2  input  32  source 2 digit word
data3  input  32  source 3 digit word
next_pulse  input  1  one-cycle skip request (debouncer key flag)
pause  input  1  level; freezes the dwell counter
disp_data  output  32  registered word to the display path
disp_valid  output  1  high while a source is granted
grant  output  4  one-hot grant, all zero in IDLE
src_idx  output  2  index of the granted source; holds its last value in IDLE

Behaviour:
- Reset (rst=1 sampled on an edge) sets: state=IDLE, grant=0, disp_valid=0, disp_data=BLANK_WORD, src_idx=0, last-grant pointer ptr=3 (source 0 wins first), dwell_cnt=0. Reset overrides all other inputs in every state.
- Arbitration function: search req circularly starting at ptr+1 mod 4, returning the first set bit. The current holder is eligible last, so it keeps the display only when it is the sole requester.
- IDLE:
  - If req==0, stay in IDLE with outputs blank.
  - Otherwise, on the next edge: grant the arbitration winner, ptr=winner, dwell_cnt=0, state=SHOW, disp_valid=1, disp_data=winner's data sampled on that edge.
  - Latency from req rising to grant/disp_data: 1 cycle.
- SHOW:
  - Every cycle, disp_data <= data of the granted source (1-cycle registered pass-through; live data changes appear after 1 cycle).
  - dwell_cnt increments each cycle while pause=0 and holds while pause=1.
- Advance event, evaluated in SHOW only. It is any of:
  - dwell_cnt==DWELL-1 with pause=0
  - next_pulse=1, honoured even while paused
  - req bit of the granted source low
- Any simultaneous combination of these causes exactly one advance.
- On advance:
  - If req!=0, grant the arbitration winner (which may be the same source), set ptr=winner, dwell_cnt=0, stay in SHOW, and load disp_data from the winner on the same edge.
  - If req==0, go to IDLE: grant=0, disp_valid=0, disp_data=BLANK_WORD, dwell_cnt=0.
- next_pulse in IDLE is ignored. pause in IDLE has no effect.
- grant is always one-hot or zero. disp_valid==(grant!=0). src_idx==index of the set grant bit whenever disp_valid=1.
- Dwell period with no skip and pause=0 is exactly DWELL cycles from grant edge to regrant edge.

Test Plan:
- Reset/idle: DWELL=8; assert rst 2 cycles, req=0 for 20 cycles -> grant=0, disp_valid=0, disp_data=32'h0 throughout.
- Rotation: DWELL=8, req=4'b1111, data_i=32'h1111_1111*(i+1) -> grant order 0,1,2,3,0 at cycles 1,9,17,25,33 after req rise; disp_data=32'h1111_1111, 32'h2222_2222, ... in step with grant.
- Skip: req=4'b0101, next_pulse high at dwell_cnt=3 -> grant moves from source 0 to 2 on the next edge, dwell_cnt=0. A simultaneous next_pulse and expiry -> exactly one advance.
- Pause: pause=1 for 20 cycles mid-dwell -> grant unchanged and dwell_cnt frozen. Skip while paused still advances. After release, the remaining dwell completes exactly.
- Sole requester / drop: req=4'b0010 -> source 1 regranted every 8 cycles with no gap. Drop req[1] -> next edge IDLE, disp_data=BLANK_WORD. Drop req[1] while req[3]=1 -> grant=4'b1000 next edge.
- Reset mid-SHOW: rst=1 while grant=4'b0100 -> next edge all outputs at reset values. After release with req=4'b1111, source 0 is granted first.
